// File: rtl/mdio_phy_responder_if.sv
// Management-side bundle of the MDIO responder: the serial MDC/MDIO pins plus
// the register-bank strobe/data path. The slave view belongs to the responder.
interface mdio_phy_responder_if;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic [4:0]  reg_addr;
    logic        reg_rd;
    logic [15:0] reg_rdata;
    logic        reg_wr;
    logic [15:0] reg_wdata;
    logic        frame_err;

    modport slave (
        input  mdc, mdio_i, reg_rdata,
        output mdio_o, mdio_oe, reg_addr, reg_rd, reg_wr, reg_wdata, frame_err
    );

    modport master (
        output mdc, mdio_i, reg_rdata,
        input  mdio_o, mdio_oe, reg_addr, reg_rd, reg_wr, reg_wdata, frame_err
    );
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO responder (PHY side). MDC and MDIO are resynchronised into the
// clk domain; bits are taken on MDC rising edges and the line is driven on MDC
// falling edges. Read/write strobes go to a local register bank.
module mdio_phy_responder #(
    parameter logic [4:0] PHY_ADDR = 5'd0,
    parameter int         MIN_PRE  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mdio_phy_responder_if.slave         bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_SKIP
    } state_t;

    localparam logic [5:0] PRE_MAX = 6'(MIN_PRE);

    // synchroniser / edge detect
    logic [2:0]  mdc_sync_q;
    logic [1:0]  mdio_sync_q;
    logic        rise_q;
    logic        fall_q;
    logic        bit_s;

    // frame state
    state_t      state_q,     state_d;
    logic [5:0]  pre_cnt_q,   pre_cnt_d;
    logic [4:0]  bit_cnt_q,   bit_cnt_d;
    logic [1:0]  op_q,        op_d;
    logic        is_rd_q,     is_rd_d;
    logic [4:0]  phy_q,       phy_d;
    logic [3:0]  regad_q,     regad_d;
    logic        ta_q,        ta_d;
    logic        fall_cnt_q,  fall_cnt_d;
    logic [15:0] shift_q,     shift_d;
    logic        rd_load_q,   rd_load_d;

    // registered outputs
    logic [4:0]  reg_addr_q,  reg_addr_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic        reg_rd_q,    reg_rd_d;
    logic        reg_wr_q,    reg_wr_d;
    logic        frame_err_q, frame_err_d;
    logic        mdio_o_q,    mdio_o_d;
    logic        mdio_oe_q,   mdio_oe_d;

    assign bit_s = mdio_sync_q[1];

    // Two-flop synchronisers; a third MDC flop yields registered edge pulses
    // that line up with the synchronised MDIO sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_sync_q  <= 3'b000;
            mdio_sync_q <= 2'b00;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            mdc_sync_q  <= {mdc_sync_q[1:0], bus.mdc};
            mdio_sync_q <= {mdio_sync_q[0], bus.mdio_i};
            rise_q      <= mdc_sync_q[1] & ~mdc_sync_q[2];
            fall_q      <= ~mdc_sync_q[1] & mdc_sync_q[2];
        end
    end

    // Frame decoder: next state, shift registers, strobes and line drive.
    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        op_d        = op_q;
        is_rd_d     = is_rd_q;
        phy_d       = phy_q;
        regad_d     = regad_q;
        ta_d        = ta_q;
        fall_cnt_d  = fall_cnt_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        mdio_o_d    = mdio_o_q;
        mdio_oe_d   = mdio_oe_q;
        reg_rd_d    = 1'b0;
        reg_wr_d    = 1'b0;
        frame_err_d = 1'b0;
        rd_load_d   = reg_rd_q;
        // read data arrives one cycle after the strobe cycle
        if (rd_load_q) begin
            shift_d = bus.reg_rdata;
        end else begin
            shift_d = shift_q;
        end

        case (state_q)
            S_IDLE: begin
                if (rise_q) begin
                    if (bit_s) begin
                        pre_cnt_d = (pre_cnt_q >= PRE_MAX) ? PRE_MAX : pre_cnt_q + 6'd1;
                    end else if (pre_cnt_q >= PRE_MAX) begin
                        state_d   = S_ST;
                        pre_cnt_d = 6'd0;
                    end else begin
                        pre_cnt_d = 6'd0;
                    end
                end else begin
                    pre_cnt_d = pre_cnt_q;
                end
            end
            S_ST: begin
                if (rise_q) begin
                    if (bit_s) begin
                        state_d   = S_OP;
                        bit_cnt_d = 5'd0;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_OP: begin
                if (rise_q) begin
                    op_d = {op_q[0], bit_s};
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                    end else begin
                        bit_cnt_d = 5'd0;
                        case ({op_q[0], bit_s})
                            2'b10: begin
                                is_rd_d = 1'b1;
                                state_d = S_PHYAD;
                            end
                            2'b01: begin
                                is_rd_d = 1'b0;
                                state_d = S_PHYAD;
                            end
                            default: begin
                                frame_err_d = 1'b1;
                                state_d     = S_IDLE;
                            end
                        endcase
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_PHYAD: begin
                if (rise_q) begin
                    phy_d = {phy_q[3:0], bit_s};
                    if (bit_cnt_q == 5'd4) begin
                        state_d   = S_REGAD;
                        bit_cnt_d = 5'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_REGAD: begin
                if (rise_q) begin
                    regad_d = {regad_q[2:0], bit_s};
                    if (bit_cnt_q == 5'd4) begin
                        reg_addr_d = {regad_q, bit_s};
                        bit_cnt_d  = 5'd0;
                        fall_cnt_d = 1'b0;
                        if (phy_q == PHY_ADDR) begin
                            reg_rd_d = is_rd_q;
                            state_d  = S_TA;
                        end else begin
                            state_d  = S_SKIP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_TA: begin
                if (is_rd_q) begin
                    // first fall: still released; second fall: drive TA bit 0
                    if (fall_q) begin
                        if (fall_cnt_q == 1'b0) begin
                            fall_cnt_d = 1'b1;
                        end else begin
                            mdio_oe_d = 1'b1;
                            mdio_o_d  = 1'b0;
                            bit_cnt_d = 5'd0;
                            state_d   = S_RDATA;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end else if (rise_q) begin
                    if (bit_cnt_q == 5'd0) begin
                        ta_d      = bit_s;
                        bit_cnt_d = 5'd1;
                    end else if ({ta_q, bit_s} == 2'b10) begin
                        bit_cnt_d = 5'd0;
                        state_d   = S_WDATA;
                    end else begin
                        // skip the remaining 16 data bits
                        frame_err_d = 1'b1;
                        bit_cnt_d   = 5'd2;
                        state_d     = S_SKIP;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_WDATA: begin
                if (rise_q) begin
                    shift_d = {shift_q[14:0], bit_s};
                    if (bit_cnt_q == 5'd15) begin
                        reg_wdata_d = {shift_q[14:0], bit_s};
                        reg_wr_d    = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_RDATA: begin
                if (fall_q) begin
                    if (bit_cnt_q == 5'd16) begin
                        mdio_oe_d = 1'b0;
                        mdio_o_d  = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        mdio_o_d  = shift_q[15];
                        shift_d   = {shift_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_SKIP: begin
                if (rise_q) begin
                    if (bit_cnt_q == 5'd17) begin
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d   = S_IDLE;
                pre_cnt_d = 6'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pre_cnt_q   <= 6'd0;
            bit_cnt_q   <= 5'd0;
            op_q        <= 2'b00;
            is_rd_q     <= 1'b0;
            phy_q       <= 5'd0;
            regad_q     <= 4'd0;
            ta_q        <= 1'b0;
            fall_cnt_q  <= 1'b0;
            shift_q     <= 16'd0;
            rd_load_q   <= 1'b0;
            reg_addr_q  <= 5'd0;
            reg_wdata_q <= 16'd0;
            reg_rd_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            mdio_o_q    <= 1'b0;
            mdio_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            op_q        <= op_d;
            is_rd_q     <= is_rd_d;
            phy_q       <= phy_d;
            regad_q     <= regad_d;
            ta_q        <= ta_d;
            fall_cnt_q  <= fall_cnt_d;
            shift_q     <= shift_d;
            rd_load_q   <= rd_load_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_rd_q    <= reg_rd_d;
            reg_wr_q    <= reg_wr_d;
            frame_err_q <= frame_err_d;
            mdio_o_q    <= mdio_o_d;
            mdio_oe_q   <= mdio_oe_d;
        end
    end

    assign bus.mdio_o    = mdio_o_q;
    assign bus.mdio_oe   = mdio_oe_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_rd    = reg_rd_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: two responders (PHYAD 0 and 1) share one
// pulled-up MDIO line driven by a behavioural SMI master. Expected behaviour
// per frame comes from the frame fields alone.
module tb_mdio_phy_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mdc = 1'b0;
    logic m_oe = 1'b0;
    logic m_bit = 1'b1;
    logic line_s;

    int n_checks = 0;
    int n_err = 0;

    logic [15:0] bank0 [32];
    logic [15:0] bank1 [32];

    mdio_phy_responder_if if0();
    mdio_phy_responder_if if1();

    mdio_phy_responder #(.PHY_ADDR(5'd0), .MIN_PRE(32)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mdio_phy_responder #(.PHY_ADDR(5'd1), .MIN_PRE(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;

    assign line_s = if0.mdio_oe ? if0.mdio_o : (if1.mdio_oe ? if1.mdio_o : (m_oe ? m_bit : 1'b1));
    assign if0.mdc = mdc;
    assign if1.mdc = mdc;
    assign if0.mdio_i = line_s;
    assign if1.mdio_i = line_s;
    assign if0.reg_rdata = bank0[if0.reg_addr];
    assign if1.reg_rdata = bank1[if1.reg_addr];

    // monitor: strobe counts, captured addresses/data, protocol violations
    int rd_n [2] = '{0, 0};
    int wr_n [2] = '{0, 0};
    int er_n [2] = '{0, 0};
    int oe_cyc [2] = '{0, 0};
    int viol = 0;
    logic [4:0]  rd_addr [2];
    logic [4:0]  wr_addr [2];
    logic [15:0] wr_data [2];
    logic        p_rd [2] = '{1'b0, 1'b0};
    logic        p_wr [2] = '{1'b0, 1'b0};
    logic        p_er [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic rd, wr, er, oe;
            rd = (d == 0) ? if0.reg_rd    : if1.reg_rd;
            wr = (d == 0) ? if0.reg_wr    : if1.reg_wr;
            er = (d == 0) ? if0.frame_err : if1.frame_err;
            oe = (d == 0) ? if0.mdio_oe   : if1.mdio_oe;
            if (rd) begin rd_n[d]++; rd_addr[d] = (d == 0) ? if0.reg_addr : if1.reg_addr; end
            if (wr) begin
                wr_n[d]++;
                wr_addr[d] = (d == 0) ? if0.reg_addr : if1.reg_addr;
                wr_data[d] = (d == 0) ? if0.reg_wdata : if1.reg_wdata;
            end
            if (er) er_n[d]++;
            if (oe) oe_cyc[d]++;
            if ((32'(rd) + 32'(wr) + 32'(er)) > 1) viol++;
            if ((rd && p_rd[d]) || (wr && p_wr[d]) || (er && p_er[d])) viol++;
            p_rd[d] = rd; p_wr[d] = wr; p_er[d] = er;
        end
        if (if0.mdio_oe && if1.mdio_oe) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // one MDC period: drive after the fall, sample just before the rise
    task automatic mbit(input logic drive, input logic b, output logic seen,
                        output logic oe0, output logic oe1);
        m_oe = drive;
        m_bit = b;
        repeat (8) @(negedge clk);
        seen = line_s;
        oe0 = if0.mdio_oe;
        oe1 = if1.mdio_oe;
        mdc = 1'b1;
        repeat (8) @(negedge clk);
        mdc = 1'b0;
    endtask

    // reset pulse during a driven read bit; nothing may follow from the aborted frame
    task automatic reset_abort();
        int r0, w0, e0;
        m_oe = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_pre_oe", 32'(if0.mdio_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_oe0", 32'(if0.mdio_oe), 32'd0);
        chk("rst_oe1", 32'(if1.mdio_oe), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r0 = rd_n[0]; w0 = wr_n[0]; e0 = er_n[0];
        repeat (40) @(negedge clk);
        chk("rst_no_rd", 32'(rd_n[0] - r0), 32'd0);
        chk("rst_no_wr", 32'(wr_n[0] - w0), 32'd0);
        chk("rst_no_err", 32'(er_n[0] - e0), 32'd0);
        chk("rst_oe_after", 32'(if0.mdio_oe), 32'd0);
    endtask

    task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                              input int abort_at, output logic [17:0] ln_v,
                              output logic [17:0] oe0_v, output logic [17:0] oe1_v);
        logic s, a0, a1;
        logic [13:0] hdr;
        ln_v = '0; oe0_v = '0; oe1_v = '0;
        for (int i = 0; i < pre; i++) mbit(1'b1, 1'b1, s, a0, a1);
        hdr = {2'b01, op, phy, ra};
        for (int i = 13; i >= 0; i--) mbit(1'b1, hdr[i], s, a0, a1);
        for (int i = 0; i < 18; i++) begin
            if (i == abort_at) begin
                reset_abort();
                return;
            end
            mbit(op != 2'b10, (i < 2) ? ta[1 - i] : wd[17 - i], s, a0, a1);
            ln_v[i] = s; oe0_v[i] = a0; oe1_v[i] = a1;
        end
        m_oe = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input int pre, input logic [1:0] op,
                                 input logic [4:0] phy, input logic [4:0] ra,
                                 input logic [1:0] ta, input logic [15:0] wd);
        int r0 [2], w0 [2], e0 [2], c0 [2], v0;
        logic [17:0] ln, o0, o1;
        logic [15:0] rd_val;
        for (int d = 0; d < 2; d++) begin
            r0[d] = rd_n[d]; w0[d] = wr_n[d]; e0[d] = er_n[d]; c0[d] = oe_cyc[d];
        end
        v0 = viol;
        send_frame(pre, op, phy, ra, ta, wd, -1, ln, o0, o1);
        repeat (12) @(negedge clk);
        for (int k = 0; k < 16; k++) rd_val[15 - k] = ln[2 + k];
        for (int d = 0; d < 2; d++) begin
            logic [17:0] ov;
            logic [15:0] bv;
            logic full, match, exp_rd, exp_wr, exp_er;
            ov = (d == 0) ? o0 : o1;
            bv = (d == 0) ? bank0[ra] : bank1[ra];
            full = (pre >= 32);
            match = (phy == 5'(d));
            exp_er = full && ((op == 2'b00) || (op == 2'b11) ||
                              (op == 2'b01 && match && ta != 2'b10));
            exp_rd = full && (op == 2'b10) && match;
            exp_wr = full && (op == 2'b01) && match && (ta == 2'b10);
            chk($sformatf("%s_d%0d_rd", tag, d), 32'(rd_n[d] - r0[d]), 32'(exp_rd));
            chk($sformatf("%s_d%0d_wr", tag, d), 32'(wr_n[d] - w0[d]), 32'(exp_wr));
            chk($sformatf("%s_d%0d_err", tag, d), 32'(er_n[d] - e0[d]), 32'(exp_er));
            if (exp_rd) begin
                chk($sformatf("%s_d%0d_raddr", tag, d), 32'(rd_addr[d]), 32'(ra));
                chk($sformatf("%s_d%0d_ta1_oe", tag, d), 32'(ov[0]), 32'd0);
                chk($sformatf("%s_d%0d_ta2_oe", tag, d), 32'(ov[1]), 32'd1);
                chk($sformatf("%s_d%0d_ta2_val", tag, d), 32'(ln[1]), 32'd0);
                chk($sformatf("%s_d%0d_rdata", tag, d), 32'(rd_val), 32'(bv));
                chk($sformatf("%s_d%0d_oe_end", tag, d),
                    32'((d == 0) ? if0.mdio_oe : if1.mdio_oe), 32'd0);
            end else begin
                chk($sformatf("%s_d%0d_no_drive", tag, d), 32'(oe_cyc[d] - c0[d]), 32'd0);
            end
            if (exp_wr) begin
                chk($sformatf("%s_d%0d_waddr", tag, d), 32'(wr_addr[d]), 32'(ra));
                chk($sformatf("%s_d%0d_wdata", tag, d), 32'(wr_data[d]), 32'(wd));
            end
        end
        chk({tag, "_protocol"}, 32'(viol - v0), 32'd0);
    endtask

    initial begin
        logic [17:0] ln, o0, o1;
        for (int i = 0; i < 32; i++) begin
            bank0[i] = 16'($urandom);
            bank1[i] = 16'($urandom);
        end
        bank0[1] = 16'h796D;

        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mdio_o", 32'(if0.mdio_o), 32'd0);
        chk("rst_mdio_oe", 32'(if0.mdio_oe), 32'd0);
        chk("rst_reg_rd", 32'(if0.reg_rd), 32'd0);
        chk("rst_reg_wr", 32'(if0.reg_wr), 32'd0);
        chk("rst_frame_err", 32'(if0.frame_err), 32'd0);
        chk("rst_reg_addr", 32'(if0.reg_addr), 32'd0);
        chk("rst_reg_wdata", 32'(if0.reg_wdata), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_and_check("read", 32, 2'b10, 5'd0, 5'h01, 2'b00, 16'h0000);
        run_and_check("write", 32, 2'b01, 5'd0, 5'h00, 2'b10, 16'h8000);
        run_and_check("short_pre", 31, 2'b10, 5'd0, 5'h01, 2'b00, 16'h0000);
        run_and_check("miss", 32, 2'b10, 5'd0, 5'h02, 2'b00, 16'h0000);
        run_and_check("hit1", 32, 2'b10, 5'd1, 5'h03, 2'b00, 16'h0000);
        run_and_check("op11", 32, 2'b11, 5'd0, 5'h02, 2'b10, 16'h1234);
        run_and_check("ta11", 32, 2'b01, 5'd0, 5'h04, 2'b11, 16'hA5A5);

        send_frame(32, 2'b10, 5'd0, 5'h05, 2'b00, 16'h0000, 10, ln, o0, o1);
        run_and_check("post_rst", 32, 2'b10, 5'd0, 5'h01, 2'b00, 16'h0000);

        for (int n = 0; n < 28; n++) begin
            logic [1:0] op, ta;
            case ($urandom_range(0, 5))
                0, 1:    op = 2'b10;
                2, 3:    op = 2'b01;
                4:       op = 2'b11;
                default: op = 2'b00;
            endcase
            ta = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
            run_and_check($sformatf("rnd%0d", n), 32 + int'($urandom_range(0, 4)), op,
                          5'($urandom_range(0, 2)), 5'($urandom), ta, 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mdio_phy_responder.md
# mdio_phy_responder

Clause-22 MDIO management responder: the PHY-side end of the MDC/MDIO link driven by the switch's SMI configuration master. It decodes serial management frames on `mdc`/`mdio`, raises single-cycle register read/write strobes toward a local register bank, and serialises read data back onto the shared line. It is used as the PHY model in port-level simulation and as the management slave in loopback/emulated-PHY builds.

## Interface
- `PHY_ADDR`, 5'd0: PHYAD this responder answers to.
- `MIN_PRE`, 32: consecutive preamble ones required before ST; legal range 1..32.

- `clk`  in  1  system clock; MDC high and low phases are each ≥4 `clk` periods.
- `rst_n`  in  1  asynchronous active-low reset.
- `mdc`  in  1  management clock from the master; asynchronous to `clk`.
- `mdio_i`  in  1  MDIO line value from the pad.
- `mdio_o`  out  1  value driven onto MDIO when enabled.
- `mdio_oe`  out  1  tristate enable; 1 = responder drives the line.
- `reg_addr`  out  5  REGAD of the current frame; held valid from the strobe until the next frame.
- `reg_rd`  out  1  one-cycle read strobe.
- `reg_rdata`  in  16  read data, sampled the `clk` cycle after `reg_rd`.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_wdata`  out  16  write data, valid with `reg_wr`.
- `frame_err`  out  1  one-cycle pulse on malformed frame.

## Operation
- `mdc` and `mdio_i` pass through 2-flop synchronisers; a third `mdc` flop gives `mdc_rise`/`mdc_fall` pulses. All bit sampling uses synced `mdio` on `mdc_rise`; all output changes happen on `mdc_fall`.
- States: IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP.
- IDLE: 6-bit preamble counter, saturating at `MIN_PRE`, increments on a sampled 1. A 0 with count ≥ `MIN_PRE` is ST bit 0 -> ST. A 0 with count < `MIN_PRE` clears the count and stays in IDLE.
- ST: expect 1, else `frame_err` -> IDLE.
- OP: 2 bits. 10 = read, 01 = write; 00/11 -> `frame_err` -> IDLE.
- PHYAD: 5 bits, MSB first. REGAD: 5 bits; `reg_addr` loads on the fifth bit.
- PHYAD ≠ `PHY_ADDR`: go to SKIP after REGAD. SKIP counts 18 rising edges (TA + 16 data) -> IDLE; no strobes, no drive, no error.
- Read, address match:
  - `reg_rd` pulses the cycle after the REGAD[0] sample.
  - `reg_rdata` loads into a 16-bit shift register on the next cycle.
  - Falls after the REGAD[0] rise are numbered F1, F2, …:
    - F1: line stays released.
    - F2: `mdio_oe`=1, `mdio_o`=0 (second TA bit).
    - F3..F18: D15..D0.
    - F19: `mdio_oe`=0, `mdio_o`=0; state -> IDLE.
- Write, address match:
  - TA samples must be 1,0; otherwise `frame_err` and SKIP the 16 data bits with no write.
  - WDATA shifts 16 bits, MSB first. After the 16th sample, `reg_wdata` updates and `reg_wr` pulses for one cycle; state -> IDLE.
- Returning to IDLE always clears the preamble count; a new frame needs a full preamble.
- No MDC timeout: a stalled `mdc` holds state indefinitely. Only `rst_n` aborts.

## Timing
- Reset values: `mdio_o`=0, `mdio_oe`=0, `reg_rd`=0, `reg_wr`=0, `frame_err`=0, `reg_addr`=0, `reg_wdata`=0, state IDLE, preamble count 0.
- `mdc_rise`/`mdc_fall` assert 3 `clk` cycles after the pin edge. `mdio_i` is sampled from its synchroniser in that same cycle.
- `mdio_o`/`mdio_oe` are registered and change 1 `clk` after `mdc_fall`, i.e. 4 `clk` after the pin falling edge.
- Strobes and `frame_err` are exactly one `clk` wide and mutually exclusive.
- `rst_n` asserted mid-read releases `mdio_oe` immediately (asynchronous). No strobe is emitted for the aborted frame.

## Test plan
- Read: 32 ones, 01, 10, PHYAD=0, REGAD=0x01, master releases at TA; `reg_rdata`=0x796D -> one `reg_rd` with `reg_addr`=0x01; line Z at TA1, 0 at TA2, then 0111100101101101; `mdio_oe` drops at F19.
- Write: PHYAD=0, REGAD=0x00, TA=10, data 0x8000 -> one `reg_wr`, `reg_wdata`=0x8000, `reg_addr`=0x00; `mdio_oe` stays 0 throughout.
- Address miss: `PHY_ADDR`=1, frame to PHYAD=0 read -> no strobe, `mdio_oe` never 1; a following read to PHYAD=1 is answered correctly.
- Short preamble: `MIN_PRE`=32, 31 ones then 01 10 … -> no strobe, no drive, no `frame_err`.
- Malformed frames: OP=11 -> `frame_err` one cycle, return to IDLE. Write with TA=11 -> `frame_err`, no `reg_wr`.
- Reset mid-read: assert `rst_n` during D7 -> `mdio_oe`=0 within the reset assertion; next full read frame is answered normally.
